pid_gain_loader: RTL and testbench
==================================

# pid_gain_loader

Avalon-MM master that pushes a complete PID gain set (kp, ki, kd) into one of several PID controller register slaves. It can optionally read all three gains back and compare them against what was written. It sits between the control/sequencing logic (or a soft-CPU bridge) and the PID gain register slaves, so gain updates for the horizontal, vertical and focus loops happen as one atomic, checked sequence rather than three loose bus writes.

## Interface
Parameters:
- TARGET_W, 3, width of the target index; up to 2**TARGET_W PID slaves
- READ_LATENCY, 1, fixed cycles from read acceptance to valid m_readdata; 0..7 legal

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state and outputs
- start  in  1  one-cycle request; sampled only in IDLE
- verify  in  1  sampled with start; 1 = perform readback after writes
- target  in  TARGET_W  slave index, sampled with start
- kp_in, ki_in, kd_in  in  16 each  signed gains, sampled with start
- m_address  out  TARGET_W+3  {target, 3'b reg}; reg 0=kp, 1=ki, 2=kd
- m_writedata  out  16  gain being written
- m_write  out  1  write request
- m_read  out  1  read request
- m_waitrequest  in  1  slave stall
- m_readdata  in  16  read data, valid READ_LATENCY cycles after read acceptance
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- error  out  1  readback mismatch; held until next accepted start or reset
- err_reg  out  2  reg index of the first mismatch; 0 when error=0

## Operation
- States: IDLE, WRITE, RD_REQ, RD_WAIT, DONE.
- IDLE
  - start=1: latch target, verify and the three gains; clear error and err_reg; set reg index idx=0; go to WRITE.
  - start while not IDLE is ignored; no queueing.
- WRITE
  - Drives m_write=1, m_address={target, idx}, m_writedata=gain[idx].
  - Address and data are held stable while m_waitrequest=1.
  - On acceptance (m_waitrequest=0), idx increments.
  - After the idx=2 acceptance: go to RD_REQ with idx=0 if verify, else go to DONE.
- RD_REQ
  - Drives m_read=1 and m_address={target, idx}, held while stalled.
  - On acceptance:
    - READ_LATENCY=0: sample m_readdata in the same cycle and compare.
    - READ_LATENCY>0: go to RD_WAIT.
- RD_WAIT
  - Counts READ_LATENCY cycles, then samples m_readdata in the last of them.
- Compare
  - Compare is a full 16-bit equality against the latched gain.
  - On the first mismatch: set error=1 and err_reg=idx. Later mismatches do not change err_reg.
  - All three registers are always read, even after a mismatch.
  - After the idx=2 compare, go to DONE; otherwise go to RD_REQ with idx+1.
- DONE: done=1 for one cycle, then IDLE.
- m_write and m_read are never asserted together. Both are 0 in IDLE, RD_WAIT and DONE.
- Latched gains are not affected by input changes after start.
- Reset mid-sequence abandons the transaction immediately, even with m_waitrequest high. No done pulse is produced. The next start runs a fresh sequence.

## Timing
- Reset values: m_address=0, m_writedata=0, m_write=0, m_read=0, busy=0, done=0, error=0, err_reg=0, state=IDLE.
- Cycle numbering: start is sampled at cycle 0; all outputs are registered.
  - busy=1 from cycle 1 through the DONE cycle inclusive.
  - done and busy deassert together the cycle after DONE.
- No stalls, verify=0:
  - writes at cycles 1, 2, 3
  - done at cycle 4
- No stalls, verify=1, READ_LATENCY=L:
  - each read occupies 1+L cycles, starting at cycle 4
  - READ_LATENCY=1: reads requested at cycles 4, 6, 8; samples at cycles 5, 7, 9; done at cycle 10
- Each stalled cycle (m_waitrequest=1 during a request) adds exactly one cycle.
- A start in the same cycle as done is ignored. A start one cycle after done is accepted.

## Test plan
- Reset, then start with target=2, kp=0x0100, ki=0x0020, kd=0xFFF0, verify=0, no stalls -> writes to addresses 0x10, 0x11, 0x12 with those data at cycles 1–3; done at cycle 4; error=0.
- Same gains with verify=1 against a behavioural slave with READ_LATENCY=1 -> reads at cycles 4, 6, 8; done at cycle 10; error=0, err_reg=0.
- Slave corrupts ki readback (returns 0x0021) -> all 3 reads still occur; done at cycle 10; error=1, err_reg=1. A following clean start clears error in cycle 1.
- m_waitrequest=1 for 3 cycles on the kd write -> address 0x12 and data 0xFFF0 held stable through the stall; done delayed by exactly 3 cycles.
- Start pulsed during WRITE, with different gains on the inputs -> ignored; the original gains are written; exactly one done.
- Reset asserted in the cycle of the ki write while stalled -> next cycle all outputs 0 and state IDLE; no done; a new start completes normally.

Source files
------------

// File: rtl/pid_gain_loader.sv
// Avalon-MM master that writes a kp/ki/kd gain set into one PID slave and
// optionally reads all three back to flag the first mismatching register.
module pid_gain_loader #(
    parameter int unsigned TARGET_W     = 3,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  verify,
    input  logic [TARGET_W-1:0]   target,
    input  logic [15:0]           kp_in,
    input  logic [15:0]           ki_in,
    input  logic [15:0]           kd_in,
    output logic [TARGET_W+2:0]   m_address,
    output logic [15:0]           m_writedata,
    output logic                  m_write,
    output logic                  m_read,
    input  logic                  m_waitrequest,
    input  logic [15:0]           m_readdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_reg
);

    localparam int unsigned GAIN_W = 16;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned LAT_W  = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2);
    localparam logic [LAT_W-1:0] LAT_LOAD =
        LAT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_REQ,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic [TARGET_W-1:0]   r_target;
    logic                  r_verify;
    logic [GAIN_W-1:0]     r_kp;
    logic [GAIN_W-1:0]     r_ki;
    logic [GAIN_W-1:0]     r_kd;

    state_t                w_state_n;
    logic [IDX_W-1:0]      w_idx_n;
    logic [LAT_W-1:0]      w_lat_cnt_n;
    logic [TARGET_W-1:0]   w_target_n;
    logic                  w_verify_n;
    logic [GAIN_W-1:0]     w_kp_n;
    logic [GAIN_W-1:0]     w_ki_n;
    logic [GAIN_W-1:0]     w_kd_n;
    logic                  w_error_n;
    logic [1:0]            w_err_reg_n;
    logic                  w_sample;
    logic                  w_mismatch;

    logic [TARGET_W+2:0]   w_address_n;
    logic [GAIN_W-1:0]     w_writedata_n;
    logic                  w_write_n;
    logic                  w_read_n;
    logic                  w_busy_n;
    logic                  w_done_n;

    function automatic logic [GAIN_W-1:0] gain_sel(
        input logic [IDX_W-1:0]  idx,
        input logic [GAIN_W-1:0] kp,
        input logic [GAIN_W-1:0] ki,
        input logic [GAIN_W-1:0] kd
    );
        logic [GAIN_W-1:0] g;
        case (idx)
            2'd0:    g = kp;
            2'd1:    g = ki;
            2'd2:    g = kd;
            default: g = '0;
        endcase
        return g;
    endfunction

    assign w_mismatch = (m_readdata != gain_sel(r_idx, r_kp, r_ki, r_kd));

    // Sequencer: next state, register index, latched request and error status
    always_comb begin
        w_state_n   = r_state;
        w_idx_n     = r_idx;
        w_lat_cnt_n = r_lat_cnt;
        w_target_n  = r_target;
        w_verify_n  = r_verify;
        w_kp_n      = r_kp;
        w_ki_n      = r_ki;
        w_kd_n      = r_kd;
        w_error_n   = error;
        w_err_reg_n = err_reg;
        w_sample    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_target_n  = target;
                    w_verify_n  = verify;
                    w_kp_n      = kp_in;
                    w_ki_n      = ki_in;
                    w_kd_n      = kd_in;
                    w_error_n   = 1'b0;
                    w_err_reg_n = 2'd0;
                    w_idx_n     = '0;
                    w_state_n   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!m_waitrequest) begin
                    if (r_idx == LAST_IDX) begin
                        w_idx_n   = '0;
                        w_state_n = r_verify ? S_RD_REQ : S_DONE;
                    end else begin
                        w_idx_n = r_idx + IDX_W'(1);
                    end
                end
            end
            S_RD_REQ: begin
                if (!m_waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        w_sample = 1'b1;
                    end else begin
                        w_lat_cnt_n = LAT_LOAD;
                        w_state_n   = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_sample = 1'b1;
                end else begin
                    w_lat_cnt_n = r_lat_cnt - LAT_W'(1);
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        // Readback compare; only the first mismatch is recorded
        if (w_sample) begin
            if (w_mismatch && !error) begin
                w_error_n   = 1'b1;
                w_err_reg_n = r_idx;
            end
            if (r_idx == LAST_IDX) begin
                w_state_n = S_DONE;
            end else begin
                w_idx_n   = r_idx + IDX_W'(1);
                w_state_n = S_RD_REQ;
            end
        end
    end

    // Bus and status values for the coming cycle, derived from the next state
    always_comb begin
        w_write_n     = (w_state_n == S_WRITE);
        w_read_n      = (w_state_n == S_RD_REQ);
        w_busy_n      = (w_state_n != S_IDLE);
        w_done_n      = (w_state_n == S_DONE);
        w_address_n   = '0;
        w_writedata_n = '0;
        if (w_write_n || w_read_n) begin
            w_address_n = {w_target_n, 1'b0, w_idx_n};
        end
        if (w_write_n) begin
            w_writedata_n = gain_sel(w_idx_n, w_kp_n, w_ki_n, w_kd_n);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_lat_cnt   <= '0;
            r_target    <= '0;
            r_verify    <= 1'b0;
            r_kp        <= '0;
            r_ki        <= '0;
            r_kd        <= '0;
            m_address   <= '0;
            m_writedata <= '0;
            m_write     <= 1'b0;
            m_read      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_reg     <= 2'd0;
        end else begin
            r_state     <= w_state_n;
            r_idx       <= w_idx_n;
            r_lat_cnt   <= w_lat_cnt_n;
            r_target    <= w_target_n;
            r_verify    <= w_verify_n;
            r_kp        <= w_kp_n;
            r_ki        <= w_ki_n;
            r_kd        <= w_kd_n;
            m_address   <= w_address_n;
            m_writedata <= w_writedata_n;
            m_write     <= w_write_n;
            m_read      <= w_read_n;
            busy        <= w_busy_n;
            done        <= w_done_n;
            error       <= w_error_n;
            err_reg     <= w_err_reg_n;
        end
    end

endmodule

// File: tb/tb_pid_gain_loader.sv
// Directed bench for pid_gain_loader against a simple register slave with
// one cycle of read latency and per-register readback corruption.
module tb_pid_gain_loader;

    localparam int unsigned TW = 3;
    localparam int unsigned AW = TW + 3;

    logic          clk;
    logic          reset;
    logic          start;
    logic          verify;
    logic [TW-1:0] target;
    logic [15:0]   kp_in;
    logic [15:0]   ki_in;
    logic [15:0]   kd_in;
    logic [AW-1:0] m_address;
    logic [15:0]   m_writedata;
    logic          m_write;
    logic          m_read;
    logic          m_waitrequest;
    logic [15:0]   m_readdata;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_reg;

    logic [15:0]   mem [64];
    logic [AW-1:0] rd_addr;
    logic [3:0]    corrupt;

    int errors = 0;
    int checks = 0;

    pid_gain_loader #(
        .TARGET_W     (TW),
        .READ_LATENCY (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .verify        (verify),
        .target        (target),
        .kp_in         (kp_in),
        .ki_in         (ki_in),
        .kd_in         (kd_in),
        .m_address     (m_address),
        .m_writedata   (m_writedata),
        .m_write       (m_write),
        .m_read        (m_read),
        .m_waitrequest (m_waitrequest),
        .m_readdata    (m_readdata),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_reg       (err_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: accepted writes land in mem; read data appears the cycle after acceptance
    always @(posedge clk) begin
        if (m_write && !m_waitrequest) mem[m_address] <= m_writedata;
        if (m_read && !m_waitrequest) rd_addr <= m_address;
    end
    assign m_readdata = mem[rd_addr] ^ {15'd0, corrupt[rd_addr[1:0]]};

    function automatic logic [15:0] gain_of(input int k);
        case (k)
            0:       return 16'h0100;
            1:       return 16'h0020;
            default: return 16'hFFF0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic start_seq(input logic vfy, input logic [TW-1:0] tg,
                             input logic [15:0] p, input logic [15:0] i, input logic [15:0] d);
        start  = 1'b1;
        verify = vfy;
        target = tg;
        kp_in  = p;
        ki_in  = i;
        kd_in  = d;
    endtask

    task automatic chk_bus(input string tag, input logic wr, input logic rd,
                           input logic [AW-1:0] addr, input logic [15:0] data,
                           input logic bsy, input logic dn);
        chk({tag, ".m_write"}, 32'(m_write), 32'(wr));
        chk({tag, ".m_read"},  32'(m_read),  32'(rd));
        chk({tag, ".busy"},    32'(busy),    32'(bsy));
        chk({tag, ".done"},    32'(done),    32'(dn));
        if (wr || rd) chk({tag, ".addr"}, 32'(m_address), 32'(addr));
        if (wr) chk({tag, ".wdata"}, 32'(m_writedata), 32'(data));
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, ".addr"},    32'(m_address),   32'd0);
        chk({tag, ".wdata"},   32'(m_writedata), 32'd0);
        chk({tag, ".m_write"}, 32'(m_write),     32'd0);
        chk({tag, ".m_read"},  32'(m_read),      32'd0);
        chk({tag, ".busy"},    32'(busy),        32'd0);
        chk({tag, ".done"},    32'(done),        32'd0);
        chk({tag, ".error"},   32'(error),       32'd0);
        chk({tag, ".err_reg"}, 32'(err_reg),     32'd0);
    endtask

    // verify=0, no stalls: writes in cycles 1..3, done in cycle 4
    task automatic run_plain(input string tag);
        int idx;
        start_seq(1'b0, 3'd2, gain_of(0), gain_of(1), gain_of(2));
        for (int c = 1; c <= 5; c++) begin
            tick();
            idx = (c <= 3) ? c - 1 : 0;
            chk_bus($sformatf("%s.c%0d", tag, c), c <= 3, 1'b0, {3'd2, 3'(idx)},
                    gain_of(idx), c <= 4, c == 4);
            if (c == 4) chk($sformatf("%s.c4.error", tag), 32'(error), 32'd0);
        end
    endtask

    // verify=1, latency 1: reads in cycles 4,6,8, done in cycle 10
    task automatic run_verify(input string tag, input logic [3:0] cor,
                              input logic exp_err, input logic [1:0] exp_reg);
        int  idx;
        logic wr;
        logic rd;
        corrupt = cor;
        start_seq(1'b1, 3'd2, gain_of(0), gain_of(1), gain_of(2));
        for (int c = 1; c <= 11; c++) begin
            tick();
            wr  = (c <= 3);
            rd  = (c == 4) || (c == 6) || (c == 8);
            idx = wr ? c - 1 : (rd ? (c - 4) / 2 : 0);
            chk_bus($sformatf("%s.c%0d", tag, c), wr, rd, {3'd2, 3'(idx)},
                    gain_of(idx), c <= 10, c == 10);
            if (c == 1) chk($sformatf("%s.c1.error", tag), 32'(error), 32'd0);
            if (c == 10) begin
                chk($sformatf("%s.c10.error", tag),   32'(error),   32'(exp_err));
                chk($sformatf("%s.c10.err_reg", tag), 32'(err_reg), 32'(exp_reg));
            end
        end
        corrupt = 4'd0;
    endtask

    initial begin
        int idx;
        reset = 1'b1;
        start = 1'b0;
        verify = 1'b0;
        target = '0;
        kp_in = '0;
        ki_in = '0;
        kd_in = '0;
        m_waitrequest = 1'b0;
        corrupt = 4'd0;
        rd_addr = '0;

        tick();
        tick();
        chk_idle_zero("reset");
        reset = 1'b0;
        tick();

        run_plain("plain");

        run_verify("ver_clean", 4'b0000, 1'b0, 2'd0);
        run_verify("ver_ki_bad", 4'b0010, 1'b1, 2'd1);
        run_verify("ver_recover", 4'b0000, 1'b0, 2'd0);
        run_verify("ver_ki_kd_bad", 4'b0110, 1'b1, 2'd1);
        run_verify("ver_kd_bad", 4'b0100, 1'b1, 2'd2);
        run_verify("ver_clean2", 4'b0000, 1'b0, 2'd0);

        // Three stalled cycles on the kd write push done from cycle 4 to 7
        start_seq(1'b0, 3'd2, gain_of(0), gain_of(1), gain_of(2));
        for (int c = 1; c <= 8; c++) begin
            tick();
            m_waitrequest = (c >= 3) && (c <= 5);
            idx = (c <= 2) ? c - 1 : 2;
            chk_bus($sformatf("stall.c%0d", c), c <= 6, 1'b0, {3'd2, 3'(idx)},
                    gain_of(idx), c <= 7, c == 7);
        end
        m_waitrequest = 1'b0;

        // Starts during WRITE and in the done cycle are both ignored
        start_seq(1'b0, 3'd2, gain_of(0), gain_of(1), gain_of(2));
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 2) start_seq(1'b1, 3'd5, 16'h1111, 16'h2222, 16'h3333);
            if (c == 4) start = 1'b1;
            idx = (c <= 3) ? c - 1 : 0;
            chk_bus($sformatf("ignore.c%0d", c), c <= 3, 1'b0, {3'd2, 3'(idx)},
                    gain_of(idx), c <= 4, c == 4);
        end

        // Reset while the ki write is stalled
        start_seq(1'b0, 3'd2, gain_of(0), gain_of(1), gain_of(2));
        tick();
        chk_bus("rst.c1", 1'b1, 1'b0, 6'h10, gain_of(0), 1'b1, 1'b0);
        tick();
        m_waitrequest = 1'b1;
        reset = 1'b1;
        chk_bus("rst.c2", 1'b1, 1'b0, 6'h11, gain_of(1), 1'b1, 1'b0);
        tick();
        reset = 1'b0;
        m_waitrequest = 1'b0;
        chk_idle_zero("rst.c3");
        for (int c = 4; c <= 6; c++) begin
            tick();
            chk_bus($sformatf("rst.c%0d", c), 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        end
        run_plain("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
